// File: rtl/spi_pkg.sv
// Shared types and constants for the single-byte SPI master.
package spi_pkg;

  localparam int unsigned SPI_WORD_W      = 8;
  localparam int unsigned CLK_DIV_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StHold,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: strobes half_tick every CLK_DIV clocks while enabled
// and toggles SCK on the strobe when toggling is allowed. SCK is forced low when disabled.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic toggle_en,
  output logic half_tick,
  output logic sck
);

  logic [7:0] cnt_q, cnt_d;
  logic       sck_q, sck_d;

  always_comb begin
    half_tick = en && (cnt_q == 8'(CLK_DIV - 1));
    cnt_d     = cnt_q + 8'd1;
    sck_d     = sck_q;
    if (!en || half_tick) begin
      cnt_d = '0;
    end
    if (!en) begin
      sck_d = 1'b0;
    end else if (half_tick && toggle_en) begin
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck = sck_q;

endmodule

// File: rtl/spi_master_core.sv
// Single-byte mode-0 SPI master, full duplex, one chip-selected frame per command edge.
// Define SPI_LSB_FIRST_EN for LSB-first bit order on MOSI and MISO (timing unchanged).
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_wr_cmd,
  input  logic                  spi_rd_cmd,
  input  logic [SPI_WORD_W-1:0] mosi_data,
  output logic [SPI_WORD_W-1:0] miso_data,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  CS,
  input  logic                  MISO,
  output logic                  busy,
  output logic                  done
);

  spi_state_e            state_q, state_d;
  logic                  req, req_q, start;
  logic [SPI_WORD_W-1:0] tx_q, tx_d, rx_q, rx_d, miso_data_q, miso_data_d;
  logic                  rd_flag_q, rd_flag_d;
  logic [3:0]            half_cnt_q, half_cnt_d;
  logic                  clk_en, toggle_en, half_tick, sck, sck_rise, sck_fall;

  assign req   = spi_wr_cmd | spi_rd_cmd;
  assign start = (state_q == StIdle) && req && !req_q;

  assign clk_en = (state_q == StSetup) || (state_q == StXfer) || (state_q == StHold);
  // The last XFER half keeps SCK low so HOLD follows a full low half-period.
  assign toggle_en = (state_q == StSetup) || ((state_q == StXfer) && (half_cnt_q != 4'd15));
  assign sck_rise  = half_tick && toggle_en && !sck;
  assign sck_fall  = half_tick && toggle_en && sck;

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (clk_en),
    .toggle_en(toggle_en),
    .half_tick(half_tick),
    .sck      (sck)
  );

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rd_flag_d   = rd_flag_q;
    half_cnt_d  = half_cnt_q;
    miso_data_d = miso_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSetup;
          tx_d      = spi_wr_cmd ? mosi_data : '0;
          rd_flag_d = spi_rd_cmd;
          rx_d      = '0;
        end
      end
      StSetup: if (half_tick) state_d = StXfer;
      StXfer: begin
        if (half_tick) begin
          half_cnt_d = half_cnt_q + 4'd1;
          if (half_cnt_q == 4'd15) state_d = StHold;
        end
      end
      StHold: begin
        if (half_tick) begin
          state_d = StDone;
          if (rd_flag_q) miso_data_d = rx_q;
        end
      end
      StDone: begin
        state_d    = StIdle;
        half_cnt_d = '0;
      end
      default: state_d = StIdle;
    endcase
`ifdef SPI_LSB_FIRST_EN
    if (sck_rise) rx_d = {MISO, rx_q[SPI_WORD_W-1:1]};
    if (sck_fall) tx_d = {1'b0, tx_q[SPI_WORD_W-1:1]};
`else
    if (sck_rise) rx_d = {rx_q[SPI_WORD_W-2:0], MISO};
    if (sck_fall) tx_d = {tx_q[SPI_WORD_W-2:0], 1'b0};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_flag_q   <= 1'b0;
      half_cnt_q  <= '0;
      miso_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rd_flag_q   <= rd_flag_d;
      half_cnt_q  <= half_cnt_d;
      miso_data_q <= miso_data_d;
    end
  end

`ifdef SPI_LSB_FIRST_EN
  assign MOSI = clk_en & tx_q[0];
`else
  assign MOSI = clk_en & tx_q[SPI_WORD_W-1];
`endif
  assign CS        = ~clk_en;
  assign SCK       = sck;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign miso_data = miso_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core with an emulated SPI slave and an expected-value queue.
module tb_spi_master_core;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_wr_cmd = 1'b0;
  logic       spi_rd_cmd = 1'b0;
  logic [7:0] mosi_data = 8'h00;
  logic [7:0] miso_data;
  logic       SCK, MOSI, CS, MISO, busy, done;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] mdl_miso = 8'h00;

  initial MISO = 1'b0;

  always #5 clk = ~clk;

  spi_master_core #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_wr_cmd(spi_wr_cmd),
    .spi_rd_cmd(spi_rd_cmd),
    .mosi_data (mosi_data),
    .miso_data (miso_data),
    .SCK       (SCK),
    .MOSI      (MOSI),
    .CS        (CS),
    .MISO      (MISO),
    .busy      (busy),
    .done      (done)
  );

  // Byte as it appears on the wire, first bit in bit 7.
  function automatic logic [7:0] wire_order(input logic [7:0] b);
    logic [7:0] r;
`ifdef SPI_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  // Drives one command and plays the slave until done (bounded). retrig toggles the command
  // during the frame and leaves it asserted afterwards.
  task automatic run_frame(input logic wr, input logic rd, input logic [7:0] tx,
                           input logic [7:0] slave, input bit retrig,
                           output int cs_low, output int rises, output int hi_bad,
                           output int first_rise, output logic mosi_hi, output logic [7:0] seen,
                           output logic [7:0] rx_at_done, output logic busy_at_done,
                           output logic timed_out);
    logic [7:0] ws;
    logic       prev;
    int         bit_idx, hi_run;
    exp_mosi_q.push_back(wire_order(wr ? tx : 8'h00));
    if (rd) mdl_miso = slave;
    exp_rx_q.push_back(mdl_miso);
    ws = wire_order(slave);
    cs_low = 0; rises = 0; hi_bad = 0; first_rise = -1; mosi_hi = 1'b0; seen = 8'h00;
    rx_at_done = 8'hxx; busy_at_done = 1'b0; timed_out = 1'b1;
    prev = 1'b0; bit_idx = 0; hi_run = 0;
    @(negedge clk);
    mosi_data  = tx;
    spi_wr_cmd = wr;
    spi_rd_cmd = rd;
    MISO       = ws[7];
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (!retrig && cyc == 10) begin
        spi_wr_cmd = 1'b0;
        spi_rd_cmd = 1'b0;
      end
      if (retrig && cyc == 20) begin
        spi_wr_cmd = 1'b0;
        spi_rd_cmd = 1'b0;
      end
      if (retrig && cyc == 30) begin
        spi_wr_cmd = wr;
        spi_rd_cmd = rd;
      end
      if (!CS) cs_low++;
      if (MOSI) mosi_hi = 1'b1;
      if (SCK) begin
        if (!prev) begin
          rises++;
          seen = {seen[6:0], MOSI};
          if (rises == 1) first_rise = cs_low - 1;
        end
        hi_run++;
      end else if (prev) begin
        if (hi_run != CLK_DIV) hi_bad++;
        hi_run = 0;
        bit_idx++;
        if (bit_idx < 8) MISO = ws[7-bit_idx];
      end
      prev = SCK;
      if (done) begin
        rx_at_done   = miso_data;
        busy_at_done = busy;
        timed_out    = 1'b0;
        break;
      end
    end
    MISO = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({CS, SCK, MOSI, busy, done, miso_data} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: got CS/SCK/MOSI/busy/done=%b%b%b%b%b miso=%h need 10000 00",
               CS, SCK, MOSI, busy, done, miso_data);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write();
    int cs_low, rises, hi_bad, first_rise, busy_seen;
    logic mosi_hi, busy_done, to;
    logic [7:0] seen, rx, e;
    run_frame(1'b1, 1'b0, 8'hC9, 8'h00, 1'b0, cs_low, rises, hi_bad, first_rise, mosi_hi, seen,
              rx, busy_done, to);
    n_checks++;
    if (to !== 1'b0) begin n_fail++; $display("FAIL write_timeout: done never seen"); end
    e = exp_mosi_q.pop_front();
    n_checks++;
    if (seen !== e) begin n_fail++; $display("FAIL write_mosi: got %h need %h", seen, e); end
    n_checks++;
    if (rises != 8) begin n_fail++; $display("FAIL write_pulses: got %0d need 8", rises); end
    n_checks++;
    if (cs_low != 18 * CLK_DIV) begin
      n_fail++; $display("FAIL write_cs_low: got %0d need %0d", cs_low, 18 * CLK_DIV);
    end
    n_checks++;
    if (first_rise != CLK_DIV) begin
      n_fail++; $display("FAIL write_first_rise: got %0d need %0d", first_rise, CLK_DIV);
    end
    n_checks++;
    if (hi_bad != 0) begin n_fail++; $display("FAIL write_sck_high: %0d bad pulses need 0", hi_bad); end
    n_checks++;
    if (busy_done !== 1'b1) begin n_fail++; $display("FAIL write_busy_at_done: got %b need 1", busy_done); end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx !== e) begin n_fail++; $display("FAIL write_miso_kept: got %h need %h", rx, e); end
    @(negedge clk);
    n_checks++;
    if ({done, CS, busy, MOSI} !== 4'b0100) begin
      n_fail++; $display("FAIL write_after_done: got done/CS/busy/MOSI=%b%b%b%b need 0100",
                         done, CS, busy, MOSI);
    end
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0) begin n_fail++; $display("FAIL write_single_frame: busy %0d cycles need 0", busy_seen); end
  endtask

  task automatic test_wr_rd();
    int cs_low, rises, hi_bad, first_rise;
    logic mosi_hi, busy_done, to;
    logic [7:0] seen, rx, e;
    run_frame(1'b1, 1'b1, 8'hC9, 8'hFF, 1'b0, cs_low, rises, hi_bad, first_rise, mosi_hi, seen,
              rx, busy_done, to);
    e = exp_mosi_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || seen !== e) begin
      n_fail++; $display("FAIL wr_rd_mosi: got %h need %h (timeout=%b)", seen, e, to);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx !== e) begin n_fail++; $display("FAIL wr_rd_miso: got %h need %h", rx, e); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_read();
    int cs_low, rises, hi_bad, first_rise;
    logic mosi_hi, busy_done, to;
    logic [7:0] seen, rx, e;
    run_frame(1'b0, 1'b1, 8'hFF, 8'hA5, 1'b0, cs_low, rises, hi_bad, first_rise, mosi_hi, seen,
              rx, busy_done, to);
    e = exp_mosi_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || seen !== e || mosi_hi !== 1'b0) begin
      n_fail++; $display("FAIL read_mosi_zero: got %h (any high=%b) need %h", seen, mosi_hi, e);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx !== e) begin n_fail++; $display("FAIL read_miso: got %h need %h", rx, e); end
    n_checks++;
    if (rises != 8) begin n_fail++; $display("FAIL read_pulses: got %0d need 8", rises); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_retrigger();
    int cs_low, rises, hi_bad, first_rise, busy_seen;
    logic mosi_hi, busy_done, to;
    logic [7:0] seen, rx, e;
    run_frame(1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, cs_low, rises, hi_bad, first_rise, mosi_hi, seen,
              rx, busy_done, to);
    void'(exp_mosi_q.pop_front());
    e = exp_rx_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || rx !== e) begin
      n_fail++; $display("FAIL retrig_miso: got %h need %h (timeout=%b)", rx, e, to);
    end
    n_checks++;
    if (cs_low != 18 * CLK_DIV) begin
      n_fail++; $display("FAIL retrig_cs_low: got %0d need %0d", cs_low, 18 * CLK_DIV);
    end
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0) begin n_fail++; $display("FAIL retrig_ignored: busy %0d cycles need 0", busy_seen); end
    spi_rd_cmd = 1'b0;
    repeat (2) @(negedge clk);
    spi_rd_cmd = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, CS} !== 2'b10) begin
      n_fail++; $display("FAIL retrig_restart: got busy/CS=%b%b need 10", busy, CS);
    end
  endtask

  // Continues from the frame left running by test_retrigger.
  task automatic test_reset_mid_frame();
    repeat (30) @(negedge clk);
    n_checks++;
    if (CS !== 1'b0) begin n_fail++; $display("FAIL midframe_active: got CS=%b need 0", CS); end
    rst_n = 1'b0;
    #1;
    mdl_miso = 8'h00;
    n_checks++;
    if ({CS, SCK, MOSI, busy, done, miso_data} !== {5'b10000, mdl_miso}) begin
      n_fail++;
      $display("FAIL midframe_reset: got CS/SCK/MOSI/busy/done=%b%b%b%b%b miso=%h need 10000 %h",
               CS, SCK, MOSI, busy, done, miso_data, mdl_miso);
    end
    spi_rd_cmd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_after_reset();
    int cs_low, rises, hi_bad, first_rise;
    logic mosi_hi, busy_done, to;
    logic [7:0] seen, rx, e;
    run_frame(1'b1, 1'b1, 8'h36, 8'h5A, 1'b0, cs_low, rises, hi_bad, first_rise, mosi_hi, seen,
              rx, busy_done, to);
    e = exp_mosi_q.pop_front();
    n_checks++;
    if (to !== 1'b0 || seen !== e) begin
      n_fail++; $display("FAIL recover_mosi: got %h need %h (timeout=%b)", seen, e, to);
    end
    e = exp_rx_q.pop_front();
    n_checks++;
    if (rx !== e) begin n_fail++; $display("FAIL recover_miso: got %h need %h", rx, e); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wr_rd();
    test_read();
    test_retrigger();
    test_reset_mid_frame();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
